palindrome_sched: RTL and testbench

- Round-robin scheduler that shares one 3-bit palindrome window engine among `NUM_REQ` serial bit requesters.
- Each grant is one frame of `FRAME_LEN` accepted bits. During the frame the granted lane streams its bits through the shared window.
- At the end of the frame the block reports how many 3-bit windows were palindromes, tagged with the requester id.
- It sits between the per-lane serial sources and the result collector, and contains the only palindrome window instance in the design.

---
 rtl/palindrome_sched.sv | 109 ++++++++++
 tb/tb_palindrome_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/palindrome_sched.sv
// palindrome_sched: round-robin scheduler sharing one 3-bit palindrome window engine; optional frame abort under PAL_SCHED_ABORT_EN
module palindrome_sched #(
  parameter int NUM_REQ   = 4,
  parameter int FRAME_LEN = 16,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int CNT_W     = $clog2(FRAME_LEN+1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] bit_vld_i,
  input  logic [NUM_REQ-1:0] bit_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               bit_rdy_o,
  output logic               pal_o,
  output logic               res_vld_o,
  output logic [ID_W-1:0]    res_id_o,
  output logic [CNT_W-1:0]   res_hits_o,
  output logic               res_all_o,
  output logic               res_abort_o,
  output logic               busy_o
);
  typedef enum logic [1:0] {IDLE, GRANT, STREAM, REPORT} state_t;
  state_t state;
  logic [ID_W-1:0] g, rr_ptr, pick, cand;
  logic [1:0] h, fill;
  logic [CNT_W-1:0] cnt, hits, hits_nxt;
  logic vld_g, bit_g, abort, accept, last;
  assign vld_g = bit_vld_i[g];
  assign bit_g = bit_i[g];
`ifdef PAL_SCHED_ABORT_EN
  assign abort = (state == STREAM) && !req_i[g];
`else
  assign abort = 1'b0;
`endif
  assign accept   = (state == STREAM) && vld_g && !abort;
  assign pal_o    = accept && (fill == 2'd2) && (h[1] == bit_g);
  assign hits_nxt = hits + CNT_W'(pal_o);
  assign last     = accept && (cnt == CNT_W'(FRAME_LEN-1));
  assign busy_o   = (state != IDLE);
  // first requesting lane at or after rr_ptr, searching upward with wrap
  always_comb begin
    pick = rr_ptr;
    cand = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_i[cand]) pick = cand;
    end
  end
  // scheduler FSM, window engine and registered result fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      g           <= '0;
      rr_ptr      <= '0;
      h           <= '0;
      fill        <= '0;
      cnt         <= '0;
      hits        <= '0;
      gnt_o       <= '0;
      bit_rdy_o   <= 1'b0;
      res_vld_o   <= 1'b0;
      res_id_o    <= '0;
      res_hits_o  <= '0;
      res_all_o   <= 1'b0;
      res_abort_o <= 1'b0;
    end else begin
      res_vld_o <= 1'b0;
      case (state)
        IDLE: if (|req_i) begin
          g     <= pick;
          gnt_o <= NUM_REQ'(1) << pick;
          state <= GRANT;
        end
        GRANT: begin
          h         <= '0;
          fill      <= '0;
          cnt       <= '0;
          hits      <= '0;
          bit_rdy_o <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            h    <= {h[0], bit_g};
            fill <= (fill == 2'd2) ? 2'd2 : fill + 2'd1;
            cnt  <= cnt + 1'b1;
            hits <= hits_nxt;
          end
          if (last || abort) begin
            state       <= REPORT;
            gnt_o       <= '0;
            bit_rdy_o   <= 1'b0;
            res_vld_o   <= 1'b1;
            res_id_o    <= g;
            res_hits_o  <= hits_nxt;
            res_all_o   <= !abort && (hits_nxt == CNT_W'(FRAME_LEN-2));
            res_abort_o <= abort;
          end
        end
        REPORT: begin
          rr_ptr <= (g == ID_W'(NUM_REQ-1)) ? '0 : g + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_palindrome_sched.sv
// tb_palindrome_sched: scoreboard bench for palindrome_sched (NUM_REQ=4, FRAME_LEN=5), both PAL_SCHED_ABORT_EN builds
module tb_palindrome_sched;
  localparam int NR = 4;
  localparam int FL = 5;
  localparam int IW = $clog2(NR);
  localparam int CW = $clog2(FL+1);
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NR-1:0] req_i = '0, bit_vld_i = '0, bit_i = '0, gnt_o;
  logic bit_rdy_o, pal_o, res_vld_o, res_all_o, res_abort_o, busy_o;
  logic [IW-1:0] res_id_o;
  logic [CW-1:0] res_hits_o;
  int passed = 0, total = 0, cyc = 0;
  typedef struct { int id; int hits; int all; int ab; } exp_t;
  exp_t q[$];

  palindrome_sched #(.NUM_REQ(NR), .FRAME_LEN(FL)) dut (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .bit_vld_i(bit_vld_i), .bit_i(bit_i),
    .gnt_o(gnt_o), .bit_rdy_o(bit_rdy_o), .pal_o(pal_o), .res_vld_o(res_vld_o),
    .res_id_o(res_id_o), .res_hits_o(res_hits_o), .res_all_o(res_all_o),
    .res_abort_o(res_abort_o), .busy_o(busy_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask

  task automatic push(input int id, input int hits, input int all, input int ab);
    exp_t e;
    e.id = id; e.hits = hits; e.all = all; e.ab = ab;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outputs(input string n);
    chk({n, "_gnt"}, int'(gnt_o), 0);
    chk({n, "_rdy"}, int'(bit_rdy_o), 0);
    chk({n, "_vld"}, int'(res_vld_o), 0);
    chk({n, "_id"}, int'(res_id_o), 0);
    chk({n, "_hits"}, int'(res_hits_o), 0);
    chk({n, "_all"}, int'(res_all_o), 0);
    chk({n, "_abort"}, int'(res_abort_o), 0);
    chk({n, "_busy"}, int'(busy_o), 0);
    chk({n, "_pal"}, int'(pal_o), 0);
  endtask

  // scoreboard monitor: pops one expected result per result pulse
  always @(negedge clk) begin
    if (res_vld_o) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got id %0d hits %0d with no expected entry", res_id_o, res_hits_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_id", int'(res_id_o), e.id);
        chk("res_hits", int'(res_hits_o), e.hits);
        chk("res_all", int'(res_all_o), e.all);
        chk("res_abort", int'(res_abort_o), e.ab);
      end
    end
  end

  // single lane frame with vld held; b[k]/pe[k] are bit k+1 and its expected pal_o
  task automatic do_frame(input string n, input int lane, input logic [4:0] b, input logic [4:0] pe,
                          input int hits, input int all);
    push(lane, hits, all, 0);
    tick(); req_i[lane] = 1'b1;
    tick();
    @(negedge clk);
    chk({n, "_gnt"}, int'(gnt_o), 1 << lane);
    chk({n, "_rdy_grant"}, int'(bit_rdy_o), 0);
    for (int k = 0; k < FL; k++) begin
      tick(); bit_vld_i[lane] = 1'b1; bit_i[lane] = b[k];
      @(negedge clk);
      chk({n, "_rdy"}, int'(bit_rdy_o), 1);
      chk({n, "_pal"}, int'(pal_o), int'(pe[k]));
    end
    tick(); bit_vld_i[lane] = 1'b0; req_i[lane] = 1'b0;
    @(negedge clk);
    chk({n, "_res_timing"}, int'(res_vld_o), 1);
    tick(); tick();
  endtask

  initial begin
    int to, last_c;
    logic [4:0] b4;
    logic [4:0] pe4;
    // reset holds everything quiet even with requests and valid bits present
    req_i = 4'b1011; bit_vld_i = 4'b1111; bit_i = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    // requests 1011 held from release: order 0,1,3,0, results 8 cycles apart, all-zero bits hit every window
    push(0, 3, 1, 0); push(1, 3, 1, 0); push(3, 3, 1, 0); push(0, 3, 1, 0);
    tick(); reset_n = 1'b1;
    last_c = 0;
    for (int n = 0; n < 4; n++) begin
      int lane;
      lane = (n == 2) ? 3 : ((n == 1) ? 1 : 0);
      to = 0;
      while (gnt_o == 0 && to < 20) begin @(negedge clk); to++; end
      chk("rr_gnt", int'(gnt_o), 1 << lane);
      to = 0;
      while (!res_vld_o && to < 20) begin @(negedge clk); to++; end
      chk("rr_res_seen", int'(res_vld_o), 1);
      if (n > 0) chk("rr_spacing", cyc - last_c, FL + 3);
      last_c = cyc;
      if (n == 3) begin req_i = '0; bit_vld_i = '0; end
      @(negedge clk);
    end
    tick(); tick();
    // lane 2 alone: 1,0,1,0,1 hits on bits 3,4,5
    do_frame("t1", 2, 5'b10101, 5'b11100, 3, 1);
    // lane 0: 1,1,0,0,1 gives no palindromic window
    do_frame("t2", 0, 5'b10011, 5'b00000, 0, 0);
    // lane 1 valid toggles while lanes 0/3 chatter; bits 1,1,1,0,1 -> hits on bits 3 and 5
    b4 = 5'b10111; pe4 = 5'b10100;
    push(1, 2, 0, 0);
    tick(); req_i[1] = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_gnt", int'(gnt_o), 4'b0010);
    for (int c = 0; c < 10; c++) begin
      tick();
      bit_vld_i[1] = (c % 2 == 0) && (c < 9);
      bit_i[1] = (c % 2 == 0) ? b4[c/2] : ~b4[(c/2) % 5];
      bit_vld_i[0] = 1'($urandom); bit_i[0] = 1'($urandom);
      bit_vld_i[3] = 1'($urandom); bit_i[3] = 1'($urandom);
      if (c == 9) req_i[1] = 1'b0;
      @(negedge clk);
      if (c < 9) begin
        chk("t4_pal", int'(pal_o), (c % 2 == 0) ? int'(pe4[c/2]) : 0);
        if (c == 8) chk("t4_no_early_res", int'(res_vld_o), 0);
      end else chk("t4_res_timing", int'(res_vld_o), 1);
    end
    tick(); bit_vld_i = '0; bit_i = '0;
    tick(); tick();
    // lane 1 drops its request after two accepted bits
`ifdef PAL_SCHED_ABORT_EN
    push(1, 0, 0, 1); pe4 = 5'b00000;
`else
    push(1, 3, 1, 0); pe4 = 5'b11100;
`endif
    tick(); req_i[1] = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_gnt", int'(gnt_o), 4'b0010);
    for (int k = 0; k < FL; k++) begin
      tick();
      if (k == 2) req_i[1] = 1'b0;
      bit_vld_i[1] = 1'b1; bit_i[1] = 1'b1;
      @(negedge clk);
      chk("t5_pal", int'(pal_o), int'(pe4[k]));
`ifdef PAL_SCHED_ABORT_EN
      if (k == 3) chk("t5_abort_res", int'(res_vld_o), 1);
`endif
    end
    tick(); bit_vld_i = '0;
`ifndef PAL_SCHED_ABORT_EN
    @(negedge clk);
    chk("t5_full_res", int'(res_vld_o), 1);
`endif
    tick(); tick(); tick();
    // reset mid-frame on lane 3 after three bits discards the frame and rr_ptr
    tick(); req_i[3] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick(); bit_vld_i[3] = 1'b1; bit_i[3] = 1'b1;
    end
    tick(); reset_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    req_i = 4'b1010; bit_vld_i = '0;
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_reset_gnt", int'(gnt_o), 4'b0010);
    reset_n = 1'b0; req_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule
